// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-to-memory-stage handshake, control and result bundle.
interface mem_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              in_valid, in_ready;
  logic              Wr, Wm, Rm, Neq, J, JC, zeroOut;
  logic [ADDR_W-1:0] PC, RegVal, branch_pc;
  logic [DATA_W-1:0] acOutValue, data_out;
  logic              saidaA, Wr_MEM, Rm_MEM, out_valid;
  modport master (
    output in_valid, Wr, Wm, Rm, Neq, J, JC, zeroOut, PC, RegVal, acOutValue,
    input  in_ready, data_out, saidaA, branch_pc, Wr_MEM, Rm_MEM, out_valid
  );
  modport slave (
    input  in_valid, Wr, Wm, Rm, Neq, J, JC, zeroOut, PC, RegVal, acOutValue,
    output in_ready, data_out, saidaA, branch_pc, Wr_MEM, Rm_MEM, out_valid
  );
endinterface

// File: rtl/mem_stage_param.sv
// mem_stage_param: pipeline memory stage with data RAM, configurable wait states,
// branch resolution and write-back control forwarding.
module mem_stage_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic       clock,
  input logic       reset_n,
  mem_stage_if.slave bus
);
  localparam int         AW       = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              l_wr, l_wm, l_rm, l_taken;
  logic [ADDR_W-1:0] l_pc, l_addr;
  logic [DATA_W-1:0] l_data;
  logic [DATA_W-1:0] ram [DEPTH];
  logic              busy, accept, go_busy, done, taken_in;
  logic              c_wr, c_wm, c_rm, c_taken, eff_rm, in_range;
  logic [ADDR_W-1:0] c_pc, c_addr;
  logic [DATA_W-1:0] c_data, rdata;
  logic [AW-1:0]     idx;
  assign busy         = state == BUSY;
  assign bus.in_ready = !busy;
  assign accept       = bus.in_valid && !busy;
  assign go_busy      = accept && (bus.Wm || bus.Rm) && WAIT_CYCLES > 0;
  assign done         = (accept && !go_busy) || (busy && cnt == 4'd0);
  assign taken_in     = bus.J | (bus.JC & (bus.zeroOut ^ bus.Neq));
  // Completing instruction: latched copy while waiting, live inputs on a same-edge completion.
  always_comb begin
    c_wr     = busy ? l_wr    : bus.Wr;
    c_wm     = busy ? l_wm    : bus.Wm;
    c_rm     = busy ? l_rm    : bus.Rm;
    c_taken  = busy ? l_taken : taken_in;
    c_pc     = busy ? l_pc    : bus.PC;
    c_addr   = busy ? l_addr  : bus.RegVal;
    c_data   = busy ? l_data  : bus.acOutValue;
    eff_rm   = c_rm & ~c_wm;
    in_range = 32'(c_addr) < DEPTH;
    idx      = c_addr[AW-1:0];
    rdata    = in_range ? ram[idx] : '0;
  end
  always_ff @(posedge clock)
    if (done && reset_n && c_wm && in_range) ram[idx] <= c_data;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      {l_wr, l_wm, l_rm, l_taken} <= '0;
      l_pc          <= '0;
      l_addr        <= '0;
      l_data        <= '0;
      bus.data_out  <= '0;
      bus.saidaA    <= 1'b0;
      bus.branch_pc <= '0;
      bus.Wr_MEM    <= 1'b0;
      bus.Rm_MEM    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= done;
      if (done) begin
        bus.data_out  <= eff_rm ? rdata : c_data;
        bus.saidaA    <= c_taken;
        bus.branch_pc <= c_pc;
        bus.Wr_MEM    <= c_wr;
        bus.Rm_MEM    <= eff_rm;
      end
      if (accept) begin
        {l_wr, l_wm, l_rm, l_taken} <= {bus.Wr, bus.Wm, bus.Rm, taken_in};
        l_pc   <= bus.PC;
        l_addr <= bus.RegVal;
        l_data <= bus.acOutValue;
      end
      if (go_busy) begin
        state <= BUSY;
        cnt   <= CNT_INIT;
      end else if (busy) begin
        state <= cnt == 4'd0 ? IDLE : BUSY;
        cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end
    end
  end
endmodule

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised memory-access stage of the 8-bit processor pipeline, sitting between execute and write-back. It owns the data RAM and executes loads and stores with a configurable number of wait states, using an in_valid/in_ready handshake to stall execute. It resolves jumps and conditional jumps from the ALU zero flag, and forwards the write-back controls Wr_MEM and Rm_MEM with a single-cycle out_valid strobe.

## Interface
- DATA_W, 8: data word width.
- ADDR_W, 8: address width of RegVal and PC.
- DEPTH, 256: number of data RAM words; must be ≤ 2^ADDR_W.
- WAIT_CYCLES, 0: extra cycles per memory access; range 0..15.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- Wr, Wm, Rm  in  1 each  register-write, memory-write and memory-read controls.
- Neq, J, JC  in  1 each  branch-on-not-equal select, unconditional jump, conditional jump.
- zeroOut  in  1  ALU zero flag.
- PC  in  ADDR_W  branch target.
- RegVal  in  ADDR_W  memory address.
- acOutValue  in  DATA_W  store data and ALU result.
- data_out  out  DATA_W  load data, or acOutValue for non-load instructions.
- saidaA  out  1  branch taken.
- branch_pc  out  ADDR_W  registered PC, meaningful when saidaA=1.
- Wr_MEM, Rm_MEM  out  1 each  registered Wr and effective Rm.
- out_valid  out  1  one-cycle strobe: outputs updated for a completed instruction.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0; counts wait states.
- Accept happens at a rising edge with in_valid=1 and in_ready=1. All inputs are latched at that edge.
- Non-memory instruction (Wm=0, Rm=0): completes at the accept edge. State stays IDLE.
- Memory instruction with WAIT_CYCLES=0: completes at the accept edge. A write stores acOutValue at RegVal; a read registers RAM[RegVal] into data_out.
- Memory instruction with WAIT_CYCLES>0:
  - The accept edge moves the FSM to BUSY and loads cnt=WAIT_CYCLES-1.
  - Each following edge decrements cnt.
  - The edge with cnt=0 performs the access, completes the instruction and returns the FSM to IDLE.
- At every completion edge:
  - out_valid=1 for exactly the next cycle.
  - data_out, saidaA, branch_pc, Wr_MEM and Rm_MEM update.
  - These outputs hold their values until the next completion.
- Branch resolution: saidaA = J | (JC & (zeroOut ^ Neq)), evaluated on latched values.
- Wm=1 and Rm=1 together: the write is performed, the read is ignored, and Rm_MEM=0.
- Address ≥ DEPTH: a write is dropped and a read returns 0. Wr_MEM and out_valid behave normally.
- RAM contents are undefined at power-up and unaffected by reset_n.

## Timing
- Reset (reset_n=0, asynchronous): FSM=IDLE, cnt=0, in_ready=1 after release, data_out=0, saidaA=0, branch_pc=0, Wr_MEM=0, Rm_MEM=0, out_valid=0.
- Reset during BUSY: the access is aborted and no RAM write occurs. No out_valid is issued for the aborted instruction.
- Latency from accept edge to completion edge:
  - Non-memory instruction: 0 edges.
  - Memory instruction: WAIT_CYCLES edges.
- Throughput:
  - Non-memory instructions: one per cycle, back to back.
  - Memory instructions: one per WAIT_CYCLES+1 cycles.
- in_ready falls combinationally with the BUSY state. in_valid is ignored while BUSY.
- A read following a write to the same address returns the new data, because the write edge precedes the read's accept.
- Write timing: RAM is written only at the completion edge, never at the accept edge when WAIT_CYCLES>0.
- Counter width: 4 bits.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately and in_ready=1. Release reset -> no out_valid until the first accept.
- Store/load, WAIT_CYCLES=2:
  - Wm=1, RegVal=0x10, acOutValue=0x5A accepted at edge 0 -> in_ready=0 for 2 cycles, out_valid after edge 2.
  - Rm=1, RegVal=0x10 -> data_out=0x5A, Rm_MEM=1, out_valid after its edge 2.
- Branches, non-memory instructions back to back:
  - J=1, PC=0x20 -> saidaA=1, branch_pc=0x20.
  - JC=1, Neq=0, zeroOut=1 -> saidaA=1.
  - JC=1, Neq=1, zeroOut=1 -> saidaA=0.
  - All three complete on consecutive cycles with no in_ready drop.
- Conflicts and range, DEPTH=128:
  - Wm=1 and Rm=1 together -> write performed, Rm_MEM=0.
  - Write of 0xFF at RegVal=0x90 -> RAM unchanged.
  - Read at RegVal=0x90 -> data_out=0x00.
- Reset abort, WAIT_CYCLES=3: Wm=1 to 0x05 with data 0xAA, reset_n pulsed in BUSY -> no out_valid, and a later read of 0x05 returns the prior value 0x11.
- Pass-through: Wr=1, acOutValue=0x3C, no memory op -> data_out=0x3C, Wr_MEM=1, out_valid one cycle after accept.
